stack_seq: RTL and testbench

- Stack transfer sequencer for the CPU datapath.
- Runs 16-bit PUSH and POP operations as byte-serial accesses on the 8-bit memory bus.
- Issues the SP-register select commands that step the stack pointer: decrement before each push write, increment after each pop read.
- Sits between the instruction decoder (start/op) and the SP register plus memory interface.

---
 rtl/stack_seq.sv | 151 +++++++++++++++
 tb/tb_stack_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_seq.sv
// Stack transfer sequencer: runs 16-bit PUSH/POP as byte-serial accesses on an 8-bit bus
// and steps SP through the SP-register select. Optional macro: STACK_SEQ_TIMEOUT_EN.
module stack_seq
`ifdef STACK_SEQ_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 16)
`endif
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] push_data,
  input  logic [15:0] sp,
  output logic [2:0]  sp_sel,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] pop_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] SP_SEL_HOLD = 3'd0;
  localparam logic [2:0] SP_SEL_INCR = 3'd1;
  localparam logic [2:0] SP_SEL_DECR = 3'd2;

  typedef enum logic [3:0] {
    IDLE, PUSH_DEC1, PUSH_WR_HI, PUSH_DEC2, PUSH_WR_LO,
    POP_RD_LO, POP_INC1, POP_RD_HI, POP_INC2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_push;
  logic [15:0] r_pop_data;
  logic [7:0]  r_lo;
  logic        r_done;
  logic        w_timeout;

`ifdef STACK_SEQ_TIMEOUT_EN
  // Per-access wait counter; cleared whenever the state changes.
  logic [7:0] r_tmo_cnt;
  logic       r_error;
  logic       w_mem;

  assign w_mem = (r_state == PUSH_WR_HI) || (r_state == PUSH_WR_LO) ||
                 (r_state == POP_RD_LO)  || (r_state == POP_RD_HI);
  assign w_timeout = w_mem && !mem_ready && (r_tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tmo_cnt <= 8'd0;
      r_error   <= 1'b0;
    end else begin
      r_error <= w_timeout;
      if (w_next != r_state)
        r_tmo_cnt <= 8'd0;
      else if (w_mem && !mem_ready)
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  assign error = r_error;
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  assign mem_addr = sp;
  assign pop_data = r_pop_data;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;

  // Next-state and bus/SP-select decode.
  always_comb begin
    w_next    = r_state;
    sp_sel    = SP_SEL_HOLD;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = 8'd0;
    case (r_state)
      IDLE: begin
        if (start) w_next = op ? POP_RD_LO : PUSH_DEC1;
      end
      PUSH_DEC1: begin
        sp_sel = SP_SEL_DECR;
        w_next = PUSH_WR_HI;
      end
      PUSH_WR_HI: begin
        mem_we    = 1'b1;
        mem_wdata = r_push[15:8];
        if (mem_ready)      w_next = PUSH_DEC2;
        else if (w_timeout) w_next = IDLE;
      end
      PUSH_DEC2: begin
        sp_sel = SP_SEL_DECR;
        w_next = PUSH_WR_LO;
      end
      PUSH_WR_LO: begin
        mem_we    = 1'b1;
        mem_wdata = r_push[7:0];
        if (mem_ready)      w_next = IDLE;
        else if (w_timeout) w_next = IDLE;
      end
      POP_RD_LO: begin
        mem_re = 1'b1;
        if (mem_ready)      w_next = POP_INC1;
        else if (w_timeout) w_next = IDLE;
      end
      POP_INC1: begin
        sp_sel = SP_SEL_INCR;
        w_next = POP_RD_HI;
      end
      POP_RD_HI: begin
        mem_re = 1'b1;
        if (mem_ready)      w_next = POP_INC2;
        else if (w_timeout) w_next = IDLE;
      end
      POP_INC2: begin
        sp_sel = SP_SEL_INCR;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_push     <= 16'd0;
      r_lo       <= 8'd0;
      r_pop_data <= 16'd0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= ((r_state == PUSH_WR_LO) && mem_ready) || (r_state == POP_INC2);
      if ((r_state == IDLE) && start && !op)
        r_push <= push_data;
      if ((r_state == POP_RD_LO) && mem_ready)
        r_lo <= mem_rdata;
      // pop_data changes only once both bytes are in hand.
      if ((r_state == POP_RD_HI) && mem_ready)
        r_pop_data <= {mem_rdata, r_lo};
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: SP register and byte memory models, with
// write and completion scoreboards filled at issue time and drained at the bus.
module tb_stack_seq;

  localparam logic [2:0] HOLD = 3'd0;
  localparam logic [2:0] INCR = 3'd1;
  localparam logic [2:0] DECR = 3'd2;

  logic        clock = 1'b0;
  logic        reset, start, op, mem_ready;
  logic [15:0] push_data, sp, mem_addr, pop_data;
  logic [2:0]  sp_sel;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_re, busy, done, error;

  always #5 clock = ~clock;

`ifdef STACK_SEQ_TIMEOUT_EN
  stack_seq #(.TIMEOUT_CYCLES(4)) dut (
`else
  stack_seq dut (
`endif
    .clock(clock), .reset(reset), .start(start), .op(op), .push_data(push_data),
    .sp(sp), .sp_sel(sp_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pop_data(pop_data), .busy(busy), .done(done), .error(error)
  );

  typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic is_pop; logic [15:0] data; } dn_t;

  wr_t wr_q[$];
  dn_t done_q[$];
  wr_t w_mon;
  dn_t d_mon;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [65536];
  logic        sp_load;
  logic [15:0] sp_load_val, sp_pend;

  logic [2:0]  sel_log   [64];
  logic        busy_log  [64];
  logic        we_log    [64];
  logic [7:0]  wdata_log [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SP register model: follows sp_sel on each rising edge.
  always @(posedge clock) sp <= sp_load ? sp_load_val : sp_pend;

  // Bus side: sample the DUT mid-cycle, serve reads, drain the scoreboards.
  always @(negedge clock) begin
    case (sp_sel)
      INCR:    sp_pend <= sp + 16'd1;
      DECR:    sp_pend <= sp - 16'd1;
      default: sp_pend <= sp;
    endcase
    mem_rdata <= mem[mem_addr];
    if (busy) check("we_re_excl", 32'(mem_we & mem_re), 32'd0);
    if (mem_we && mem_ready) begin
      mem[mem_addr] <= mem_wdata;
      if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else begin
        w_mon = wr_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(w_mon.addr));
        check("wr_data", 32'(mem_wdata), 32'(w_mon.data));
      end
    end
    if (done) begin
      check("done_err_excl", 32'(error), 32'd0);
      if (done_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
      else begin
        d_mon = done_q.pop_front();
        if (d_mon.is_pop) check("pop_data", 32'(pop_data), 32'(d_mon.data));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive start for one edge and register what the operation must produce.
  task automatic issue(input logic op_i, input logic [15:0] data, input logic exp_done);
    wr_t t;
    dn_t d;
    start = 1'b1;
    op = op_i;
    push_data = data;
    if (exp_done) begin
      if (!op_i) begin
        t.addr = sp - 16'd1; t.data = data[15:8]; wr_q.push_back(t);
        t.addr = sp - 16'd2; t.data = data[7:0];  wr_q.push_back(t);
        d.is_pop = 1'b0; d.data = 16'h0000;
      end else begin
        d.is_pop = 1'b1; d.data = {mem[sp + 16'd1], mem[sp]};
      end
      done_q.push_back(d);
    end
    tick();
    start = 1'b0;
  endtask

  // Step until done; ready is held low for nwait cycles starting at cycle wlo.
  task automatic wait_done(input int wlo, input int nwait, input int pulse_cyc, output int dcyc);
    dcyc = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      mem_ready = !(cyc >= wlo && cyc < wlo + nwait);
      if (cyc == pulse_cyc) begin
        start = 1'b1;
        op = 1'b1;
      end else start = 1'b0;
      sel_log[cyc]   = sp_sel;
      busy_log[cyc]  = busy;
      we_log[cyc]    = mem_we;
      wdata_log[cyc] = mem_wdata;
      if (done) begin
        dcyc = cyc;
        break;
      end
      tick();
    end
    start = 1'b0;
    mem_ready = 1'b1;
    if (dcyc == 0) check("done_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    logic [15:0] sp_before;
    logic [2:0] exp_push_sel [4];
    logic [2:0] exp_pop_sel  [4];
    exp_push_sel = '{DECR, HOLD, DECR, HOLD};
    exp_pop_sel  = '{HOLD, INCR, HOLD, INCR};

    reset = 1'b0; start = 1'b0; op = 1'b0; push_data = 16'h0; mem_ready = 1'b1;
    sp_load = 1'b1; sp_load_val = 16'hFFFE;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_pop_data", 32'(pop_data), 32'd0);
    check("rst_sp_sel", 32'(sp_sel), 32'(HOLD));
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_re", 32'(mem_re), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b1;
    sp_load = 1'b0;
    tick();

    // PUSH 0xBEEF from SP 0xFFFE, zero wait.
    issue(1'b0, 16'hBEEF, 1'b1);
    wait_done(0, 0, 0, d);
    check("push_done_cyc", 32'(d), 32'd5);
    for (int i = 1; i <= 4; i++) begin
      check("push_sp_sel", 32'(sel_log[i]), 32'(exp_push_sel[i-1]));
      check("push_busy", 32'(busy_log[i]), 32'd1);
    end
    check("push_busy_at_done", 32'(busy), 32'd0);
    check("push_final_sp", 32'(sp), 32'hFFFC);

    // POP back from SP 0xFFFC.
    issue(1'b1, 16'h0000, 1'b1);
    wait_done(0, 0, 0, d);
    check("pop_done_cyc", 32'(d), 32'd5);
    for (int i = 1; i <= 4; i++)
      check("pop_sp_sel", 32'(sel_log[i]), 32'(exp_pop_sel[i-1]));
    check("pop_final_sp", 32'(sp), 32'hFFFE);
    check("pop_value", 32'(pop_data), 32'hBEEF);

    // PUSH with three wait cycles on the high-byte write.
    issue(1'b0, 16'hBEEF, 1'b1);
    wait_done(2, 3, 0, d);
    check("wait_done_cyc", 32'(d), 32'd8);
    for (int i = 2; i <= 4; i++) begin
      check("wait_we_held", 32'(we_log[i]), 32'd1);
      check("wait_wdata_held", 32'(wdata_log[i]), 32'hBE);
    end
    check("wait_final_sp", 32'(sp), 32'hFFFC);

    // Start while busy is dropped; start on the done cycle chains a POP.
    issue(1'b0, 16'hA55A, 1'b1);
    wait_done(0, 0, 2, d);
    check("ign_done_cyc", 32'(d), 32'd5);
    issue(1'b1, 16'h0000, 1'b1);
    wait_done(0, 0, 0, d);
    check("chain_busy_first", 32'(busy_log[1]), 32'd1);
    check("chain_done_cyc", 32'(d), 32'd5);
    check("chain_final_sp", 32'(sp), 32'hFFFC);

    // Reset while POP_RD_HI waits: abort with no done.
    issue(1'b1, 16'h0000, 1'b0);
    tick();
    tick();
    check("rmp_in_rd_hi", 32'(mem_re), 32'd1);
    mem_ready = 1'b0;
    reset = 1'b0;
    tick();
    check("rmp_busy", 32'(busy), 32'd0);
    check("rmp_re", 32'(mem_re), 32'd0);
    check("rmp_sp_sel", 32'(sp_sel), 32'(HOLD));
    check("rmp_pop_data", 32'(pop_data), 32'd0);
    check("rmp_done", 32'(done), 32'd0);
    reset = 1'b1;
    mem_ready = 1'b1;
    sp_load = 1'b1; sp_load_val = 16'h0001;
    tick();
    sp_load = 1'b0;
    tick();

    // PUSH across the SP wrap, then POP it back.
    issue(1'b0, 16'hC3A5, 1'b1);
    wait_done(0, 0, 0, d);
    check("wrap_final_sp", 32'(sp), 32'hFFFF);
    issue(1'b1, 16'h0000, 1'b1);
    wait_done(0, 0, 0, d);
    check("wrap_pop_sp", 32'(sp), 32'h0001);

`ifdef STACK_SEQ_TIMEOUT_EN
    // POP with ready stuck low aborts after four wait cycles.
    sp_before = sp;
    mem_ready = 1'b0;
    issue(1'b1, 16'h0000, 1'b0);
    d = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (error) begin
        d = cyc;
        break;
      end
      tick();
    end
    check("tmo_err_cyc", 32'(d), 32'd5);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_re", 32'(mem_re), 32'd0);
    check("tmo_pop_data", 32'(pop_data), 32'hC3A5);
    check("tmo_sp", 32'(sp), 32'(sp_before));
    tick();
    check("tmo_err_pulse", 32'(error), 32'd0);
    mem_ready = 1'b1;
`else
    sp_before = sp;
    check("no_tmo_error", 32'(error), 32'd0);
`endif

    repeat (5) tick();
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
